// File: rtl/ps2_line_buffer.sv
// Line editor behind the PS/2-to-ASCII decoder: edits a line, then streams it out on enter.
// Optional echo outputs are enabled by defining LOCAL_ECHO_EN.
module ps2_line_buffer #(
  parameter int DEPTH_BITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  new_code,
  input  logic [6:0]            ascii_code,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [6:0]            out_data,
  output logic                  out_last,
  output logic [DEPTH_BITS-1:0] line_len,
  output logic                  busy,
  output logic                  drop
`ifdef LOCAL_ECHO_EN
  ,
  output logic                  echo_strobe,
  output logic [6:0]            echo_data
`endif
);

  // Handshake: a byte moves when out_valid && out_ready on a rising edge;
  // out_data/out_last hold while out_valid && !out_ready.

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS-1:0] LAST_IDX = DEPTH_BITS'(DEPTH - 1);

  typedef enum logic {EDIT, DRAIN} state_t;

  state_t                  state, state_nx;
  logic [DEPTH_BITS-1:0]   count, count_nx;
  logic [DEPTH_BITS-1:0]   rd_ptr, rd_ptr_nx;
  logic                    drop_nx;
  logic                    wr_en;
  logic [6:0]              wr_data;
  logic                    printable;
  logic [6:0]              mem [DEPTH];

`ifdef LOCAL_ECHO_EN
  logic                    echo_nx;
  logic [6:0]              echo_data_nx;
`endif

  assign printable = (ascii_code >= 7'h20) && (ascii_code <= 7'h7E);

  // The terminator lands at index count, so count doubles as the last index during DRAIN.
  always_comb begin
    state_nx  = state;
    count_nx  = count;
    rd_ptr_nx = rd_ptr;
    drop_nx   = 1'b0;
    wr_en     = 1'b0;
    wr_data   = ascii_code;
`ifdef LOCAL_ECHO_EN
    echo_nx      = 1'b0;
    echo_data_nx = ascii_code;
`endif
    case (state)
      EDIT: begin
        if (new_code) begin
          if (printable) begin
            if (count != LAST_IDX) begin
              wr_en    = 1'b1;
              count_nx = count + DEPTH_BITS'(1);
`ifdef LOCAL_ECHO_EN
              echo_nx  = 1'b1;
`endif
            end else begin
              drop_nx = 1'b1;
            end
          end else if (ascii_code == 7'h08) begin
            if (count != '0) begin
              count_nx = count - DEPTH_BITS'(1);
`ifdef LOCAL_ECHO_EN
              echo_nx      = 1'b1;
              echo_data_nx = 7'h08;
`endif
            end
          end else if (ascii_code == 7'h1B) begin
            count_nx = '0;
          end else if ((ascii_code == 7'h0D) || (ascii_code == 7'h0A)) begin
            wr_en     = 1'b1;
            wr_data   = 7'h0D;
            rd_ptr_nx = '0;
            state_nx  = DRAIN;
`ifdef LOCAL_ECHO_EN
            echo_nx      = 1'b1;
            echo_data_nx = 7'h0D;
`endif
          end
        end
      end
      DRAIN: begin
        drop_nx = new_code;
        if (out_ready) begin
          if (rd_ptr == count) begin
            state_nx  = EDIT;
            count_nx  = '0;
            rd_ptr_nx = '0;
          end else begin
            rd_ptr_nx = rd_ptr + DEPTH_BITS'(1);
          end
        end
      end
      default: state_nx = EDIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= EDIT;
      count  <= '0;
      rd_ptr <= '0;
      drop   <= 1'b0;
    end else begin
      state  <= state_nx;
      count  <= count_nx;
      rd_ptr <= rd_ptr_nx;
      drop   <= drop_nx;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[count] <= wr_data;
  end

`ifdef LOCAL_ECHO_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      echo_strobe <= 1'b0;
      echo_data   <= '0;
    end else begin
      echo_strobe <= echo_nx;
      echo_data   <= echo_data_nx;
    end
  end
`endif

  assign out_valid = (state == DRAIN);
  assign busy      = (state == DRAIN);
  assign out_data  = mem[rd_ptr];
  assign out_last  = (state == DRAIN) && (rd_ptr == count);
  assign line_len  = count;

endmodule

// File: tb/tb_ps2_line_buffer.sv
// Randomized bench for ps2_line_buffer against a queue-based line model.
// Define LOCAL_ECHO_EN to also check the echo outputs.
module tb_ps2_line_buffer;
  localparam int DB    = 5;
  localparam int DEPTH = 1 << DB;

  logic          clk = 1'b0;
  logic          reset;
  logic          new_code;
  logic [6:0]    ascii_code;
  logic          out_valid;
  logic          out_ready;
  logic [6:0]    out_data;
  logic          out_last;
  logic [DB-1:0] line_len;
  logic          busy;
  logic          drop;
`ifdef LOCAL_ECHO_EN
  logic          echo_strobe;
  logic [6:0]    echo_data;
`endif

  ps2_line_buffer #(.DEPTH_BITS(DB)) dut (
    .clk        (clk),
    .reset      (reset),
    .new_code   (new_code),
    .ascii_code (ascii_code),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .line_len   (line_len),
    .busy       (busy),
    .drop       (drop)
`ifdef LOCAL_ECHO_EN
    ,
    .echo_strobe(echo_strobe),
    .echo_data  (echo_data)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: line_q is the edit line, exp_q holds {last, byte} still to be streamed.
  logic [6:0] line_q[$];
  logic [7:0] exp_q[$];
  logic       exp_drop;
  logic       exp_echo;
  logic [6:0] exp_echo_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    line_q.delete();
    exp_q.delete();
    exp_drop      = 1'b0;
    exp_echo      = 1'b0;
    exp_echo_data = '0;
  endtask

  task automatic check_outputs();
    logic [7:0] head;
    check("out_valid", out_valid, exp_q.size() > 0);
    check("busy", busy, exp_q.size() > 0);
    check("line_len", line_len, line_q.size());
    check("drop", drop, exp_drop);
    if (exp_q.size() > 0) begin
      head = exp_q[0];
      check("out_data", out_data, head[6:0]);
      check("out_last", out_last, head[7]);
    end
`ifdef LOCAL_ECHO_EN
    check("echo_strobe", echo_strobe, exp_echo);
    if (exp_echo) check("echo_data", echo_data, exp_echo_data);
`endif
  endtask

  // One clock: drive inputs, check outputs at negedge, advance the model.
  task automatic step(input logic nc, input logic [6:0] code, input logic rdy);
    logic nd, ne;
    logic [6:0] ed;
    new_code   = nc;
    ascii_code = code;
    out_ready  = rdy;
    @(negedge clk);
    check_outputs();
    nd = 1'b0;
    ne = 1'b0;
    ed = code;
    if (exp_q.size() > 0) begin
      nd = nc;
      if (rdy) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) line_q.delete();
      end
    end else if (nc) begin
      if (code >= 7'h20 && code <= 7'h7E) begin
        if (line_q.size() < DEPTH - 1) begin
          line_q.push_back(code);
          ne = 1'b1;
        end else begin
          nd = 1'b1;
        end
      end else if (code == 7'h08) begin
        if (line_q.size() > 0) begin
          void'(line_q.pop_back());
          ne = 1'b1;
        end
      end else if (code == 7'h1B) begin
        line_q.delete();
      end else if (code == 7'h0D || code == 7'h0A) begin
        foreach (line_q[i]) exp_q.push_back({1'b0, line_q[i]});
        exp_q.push_back({1'b1, 7'h0D});
        ne = 1'b1;
        ed = 7'h0D;
      end
    end
    exp_drop      = nd;
    exp_echo      = ne;
    exp_echo_data = ed;
    @(posedge clk);
    #1;
  endtask

  task automatic type_char(input logic [6:0] c);
    step(1'b1, c, 1'b0);
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() > 0 && n < max_cycles) begin
      step(1'b0, 7'h00, 1'b1);
      n++;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_clear();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_line_len", line_len, 0);
    check("rst_drop", drop, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] rand_char(input bit long_lines);
    int r = $urandom_range(0, 99);
    int enter_w = long_lines ? 1 : 10;
    if (r < 70) return 7'($urandom_range(32, 126));
    if (r < 82) return 7'h08;
    if (r < 86) return 7'h1B;
    if (r < 86 + enter_w) return ($urandom_range(0, 1) != 0) ? 7'h0D : 7'h0A;
    return ($urandom_range(0, 1) != 0) ? 7'h7F : 7'($urandom_range(0, 7));
  endfunction

  initial begin
    reset      = 1'b0;
    new_code   = 1'b0;
    ascii_code = '0;
    out_ready  = 1'b0;
    #12;
    do_reset();

    // "Hi" at full rate
    type_char(7'h48); type_char(7'h69);
    step(1'b1, 7'h0D, 1'b1);
    drain(10);
    step(1'b0, 7'h00, 1'b1);

    // Backspace editing and backspace on empty line
    type_char(7'h61); type_char(7'h62); type_char(7'h08); type_char(7'h63); type_char(7'h0D);
    drain(10);
    type_char(7'h08); type_char(7'h0D);
    drain(10);

    // Overfill: 31 stored, 32nd dropped, then 32 bytes out
    for (int i = 0; i < DEPTH; i++) type_char(7'($urandom_range(32, 126)));
    step(1'b0, 7'h00, 1'b0);
    type_char(7'h0A);
    drain(40);

    // Stalled consumer, then toggling ready, with a strobe mid-drain
    type_char(7'h78); type_char(7'h79); type_char(7'h7A); type_char(7'h0D);
    for (int i = 0; i < 5; i++) step(1'b0, 7'h00, 1'b0);
    step(1'b1, 7'h71, 1'b1);
    step(1'b0, 7'h00, 1'b0);
    step(1'b0, 7'h00, 1'b1);
    step(1'b0, 7'h00, 1'b0);
    drain(10);
    step(1'b0, 7'h00, 1'b0);

    // Escape clears the line
    type_char(7'h6B); type_char(7'h1B); type_char(7'h0D);
    drain(10);

    // Echo: second backspace on empty line is silent
    type_char(7'h61); type_char(7'h08); type_char(7'h08); type_char(7'h0D);
    drain(10);

    // Reset mid-drain of "abc" after the first byte
    type_char(7'h61); type_char(7'h62); type_char(7'h63); type_char(7'h0D);
    step(1'b0, 7'h00, 1'b1);
    do_reset();
    step(1'b0, 7'h00, 1'b1);

    // Randomized traffic, alternating short and long-line phases
    for (int phase = 0; phase < 6; phase++) begin
      for (int i = 0; i < 500; i++) begin
        step($urandom_range(0, 99) < 60, rand_char(phase[0]), $urandom_range(0, 99) < 60);
      end
    end
    drain(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
